// File: rtl/router_term_src.sv
// rtl/router_term_src.sv - terminal-side packet source: packet assembly, FWFT FIFO, status flags
// Optional feature macro: ROUTER_SRC_SELF_DST_CHK_EN (reject packets addressed to this terminal)
module router_term_src #(
  parameter int ROWS    = 4,
  parameter int COLUMS  = 4,
  parameter int PCK_SZ  = 40,
  parameter int N_TERMS = 2*ROWS+2*COLUMS,
  parameter int TERM_ID = 0,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [5:0]                 wr_dst,
  input  logic [PCK_SZ-21:0]         wr_payload,
  output logic                       wr_ack,
  output logic [PCK_SZ-1:0]          data_out_i_in,
  output logic                       pndng_i_in,
  input  logic                       popin,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  input  logic                       clr_err,
  output logic                       err_ovf,
  output logic                       err_dst,
  output logic                       err_pop,
  output logic                       stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [6:0] NT = 7'(N_TERMS);

  logic [PCK_SZ-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [7:0]        seq;
  logic [WW-1:0]     wait_cnt;
  logic              dst_ok;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              dst_set;
  logic              pop_set;
  logic              stall_set;
  logic              wait_inc;
  logic [PCK_SZ-1:0] pkt;

  // Destination validity, optionally excluding self-addressed packets
  always_comb begin
    dst_ok = ({1'b0, wr_dst} < NT);
`ifdef ROUTER_SRC_SELF_DST_CHK_EN
    if (wr_dst == 6'(TERM_ID)) dst_ok = 1'b0;
`else
    dst_ok = dst_ok & 1'b1;
`endif
  end

  // Handshake decode and flag-set conditions; full is the registered occupancy view
  always_comb begin
    full       = (count == CW'(DEPTH));
    pndng_i_in = (count != '0);
    push       = wr_en & ~full & dst_ok;
    wr_ack     = push;
    pop        = popin & pndng_i_in;
    ovf_set    = wr_en & full;
    dst_set    = wr_en & ~full & ~dst_ok;
    pop_set    = popin & ~pndng_i_in;
    wait_inc   = pndng_i_in & ~popin;
    stall_set  = wait_inc & (wait_cnt >= WW'(TIMEOUT - 1));
    pkt        = {wr_dst, 6'(TERM_ID), seq, wr_payload};
    data_out_i_in = pndng_i_in ? mem[rd_ptr] : '0;
  end

  // Packet storage; contents past the head are don't-care, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pkt;
  end

  // Pointers, occupancy and sequence number
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      seq    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        seq    <= seq + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Head wait counter: counts unserved pending cycles, saturating at the stall threshold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!wait_inc) begin
      wait_cnt <= '0;
    end else if (wait_cnt < WW'(TIMEOUT)) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Sticky status flags; a set condition overrides a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_dst <= 1'b0;
      err_pop <= 1'b0;
      stall   <= 1'b0;
    end else begin
      err_ovf <= ovf_set   | (err_ovf & ~clr_err);
      err_dst <= dst_set   | (err_dst & ~clr_err);
      err_pop <= pop_set   | (err_pop & ~clr_err);
      stall   <= stall_set | (stall & ~clr_err);
    end
  end

endmodule

// File: tb/tb_router_term_src.sv
// tb/tb_router_term_src.sv - self-checking bench for router_term_src with a queue-based model
module tb_router_term_src;

  localparam int ROWS    = 4;
  localparam int COLUMS  = 4;
  localparam int PCK_SZ  = 40;
  localparam int N_TERMS = 16;
  localparam int TERM_ID = 2;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 128;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [5:0]        wr_dst;
  logic [19:0]       wr_payload;
  logic              wr_ack;
  logic [39:0]       data_out_i_in;
  logic              pndng_i_in;
  logic              popin;
  logic [3:0]        count;
  logic              full;
  logic              clr_err;
  logic              err_ovf;
  logic              err_dst;
  logic              err_pop;
  logic              stall;

  int errors = 0;
  int checks = 0;

  router_term_src #(
    .ROWS(ROWS), .COLUMS(COLUMS), .PCK_SZ(PCK_SZ), .N_TERMS(N_TERMS),
    .TERM_ID(TERM_ID), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_dst(wr_dst), .wr_payload(wr_payload),
    .wr_ack(wr_ack), .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin),
    .count(count), .full(full), .clr_err(clr_err), .err_ovf(err_ovf), .err_dst(err_dst),
    .err_pop(err_pop), .stall(stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: packets as a queue, counters as integers
  logic [39:0] mq[$];
  int          m_seq;
  int          m_wait;
  bit          m_ovf, m_dst, m_pop, m_stall;
  bit          m_pend, m_full, m_acc;

  function automatic bit dst_valid(input logic [5:0] d);
    bit ok;
    ok = (int'(d) < N_TERMS);
`ifdef ROUTER_SRC_SELF_DST_CHK_EN
    if (int'(d) == TERM_ID) ok = 0;
`endif
    return ok;
  endfunction

  function automatic bit model_ack();
    return wr_en && (mq.size() < DEPTH) && dst_valid(wr_dst);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_seq = 0; m_wait = 0;
      m_ovf = 0; m_dst = 0; m_pop = 0; m_stall = 0;
    end else begin
      m_pend = (mq.size() > 0);
      m_full = (mq.size() == DEPTH);
      m_acc  = model_ack();
      if (!m_pend || popin) m_wait = 0;
      else if (m_wait < TIMEOUT) m_wait = m_wait + 1;
      m_ovf   = (wr_en && m_full) || (m_ovf && !clr_err);
      m_dst   = (wr_en && !m_full && !dst_valid(wr_dst)) || (m_dst && !clr_err);
      m_pop   = (popin && !m_pend) || (m_pop && !clr_err);
      m_stall = (m_pend && !popin && m_wait == TIMEOUT) || (m_stall && !clr_err);
      if (popin && m_pend) void'(mq.pop_front());
      if (m_acc) begin
        mq.push_back({wr_dst, 6'(TERM_ID), 8'(m_seq), wr_payload});
        m_seq = (m_seq + 1) % 256;
      end
    end
  end

  // Compare every cycle, mid-period, away from the active edge
  always @(negedge clk) begin
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_pndng", 64'(pndng_i_in), 64'(mq.size() > 0));
    chk("m_full", 64'(full), 64'(mq.size() == DEPTH));
    chk("m_data", 64'(data_out_i_in), (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
    chk("m_ack", 64'(wr_ack), 64'(model_ack()));
    chk("m_ovf", 64'(err_ovf), 64'(m_ovf));
    chk("m_dst", 64'(err_dst), 64'(m_dst));
    chk("m_pop", 64'(err_pop), 64'(m_pop));
    chk("m_stall", 64'(stall), 64'(m_stall));
  end

  task automatic cyc(input bit we, input logic [5:0] d, input logic [19:0] p, input bit pop, input bit clr);
    wr_en = we; wr_dst = d; wr_payload = p; popin = pop; clr_err = clr;
    @(posedge clk); #1;
    wr_en = 0; popin = 0; clr_err = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    reset = 1; wr_en = 0; wr_dst = 0; wr_payload = 0; popin = 0; clr_err = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_pndng", 64'(pndng_i_in), 0);
    chk("rst_data", 64'(data_out_i_in), 0);
    reset = 0;

    // Single packet through
    cyc(1, 6'd5, 20'hABCDE, 0, 0);
    chk("first_pndng", 64'(pndng_i_in), 1);
    chk("first_pkt", 64'(data_out_i_in), 64'h14200ABCDE);
    cyc(0, 0, 0, 1, 0);
    chk("pop_pndng", 64'(pndng_i_in), 0);
    chk("pop_count", 64'(count), 0);

    // Fill, overflow, drain in order
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 6'(i), 20'(i * 17), 0, 0);
    chk("fill_full", 64'(full), 1);
    wr_en = 1; wr_dst = 6'd3; wr_payload = 20'h1;
    #1;
    chk("ovf_ack", 64'(wr_ack), 0);
    @(posedge clk); #1;
    wr_en = 0;
    chk("ovf_flag", 64'(err_ovf), 1);
    for (int i = 0; i < 8; i++) begin
      chk("drain_seq", 64'(data_out_i_in[27:20]), 64'(i));
      cyc(0, 0, 0, 1, 0);
    end
    cyc(1, 6'd1, 20'h2, 0, 0);
    chk("seq_held", 64'(data_out_i_in[27:20]), 8);
    cyc(0, 0, 0, 1, 1);

    // Invalid destination
    cyc(1, 6'd16, 20'h5, 0, 0);
    chk("bad_dst_flag", 64'(err_dst), 1);
    chk("bad_dst_count", 64'(count), 0);
    cyc(0, 0, 0, 0, 1);
    chk("bad_dst_clr", 64'(err_dst), 0);

    // Illegal pop, full push+pop
    cyc(0, 0, 0, 1, 0);
    chk("epop_flag", 64'(err_pop), 1);
    chk("epop_count", 64'(count), 0);
    for (int i = 0; i < 8; i++) cyc(1, 6'(15 - i), 20'(i), 0, 0);
    cyc(1, 6'd4, 20'h9, 1, 0);
    chk("fullpp_count", 64'(count), 7);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 0);

    // Stall threshold
    do_reset();
    cyc(1, 6'd7, 20'h77, 0, 0);
    for (int i = 0; i < 127; i++) cyc(0, 0, 0, 0, 0);
    chk("stall_127", 64'(stall), 0);
    cyc(0, 0, 0, 0, 0);
    chk("stall_128", 64'(stall), 1);
    cyc(0, 0, 0, 1, 0);
    chk("stall_held", 64'(stall), 1);
    cyc(0, 0, 0, 0, 1);
    chk("stall_clr", 64'(stall), 0);
    cyc(0, 0, 0, 1, 1);
    chk("set_beats_clr", 64'(err_pop), 1);

    // Sequence wrap
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1, 6'(i % 16), 20'(i), i > 0, 0);
      if (i == 255) chk("seq_255", 64'(data_out_i_in[27:20]), 255);
      if (i == 256) chk("seq_wrap", 64'(data_out_i_in[27:20]), 0);
    end

    // Self-addressed packet
    do_reset();
    cyc(1, 6'(TERM_ID), 20'h3, 0, 0);
`ifdef ROUTER_SRC_SELF_DST_CHK_EN
    chk("self_dst_flag", 64'(err_dst), 1);
    chk("self_count", 64'(count), 0);
`else
    chk("self_dst_flag", 64'(err_dst), 0);
    chk("self_count", 64'(count), 1);
`endif

    // Mixed traffic pattern
    for (int i = 0; i < 200; i++)
      cyc(i % 3 != 0, (i % 7 == 0) ? 6'd20 : 6'(i % 16), 20'(i * 31), (i % 4 == 1) || (i % 5 == 0), i % 11 == 0);

    // Asynchronous reset mid-operation
    cyc(1, 6'd1, 20'h1, 0, 0);
    cyc(1, 6'd2, 20'h2, 0, 0);
    reset = 1;
    #1;
    chk("async_count", 64'(count), 0);
    chk("async_pndng", 64'(pndng_i_in), 0);
    chk("async_data", 64'(data_out_i_in), 0);
    @(posedge clk); #1;
    reset = 0;
    cyc(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
